// File: rtl/apb_irq_event_ctrl.sv
// apb_irq_event_ctrl
//   APB interrupt/event controller with an integrated core sleep controller.
//   Captures NB_LINES irq and event sources (per-line edge or level),
//   exposes mask/pending/set registers and a prioritised IRQ ID. A sleep
//   FSM gates the core clock and fetch enable. After a wake-up it holds
//   fetch off for WAKE_CYCLES cycles while the core clock settles.
//
// Ports
//   HCLK, HRESETn        clock, async active-low reset
//   PADDR..PSLVERR       APB slave, zero wait states, PADDR[4:2] decoded
//   irq_i, event_i       sources, synchronous to HCLK
//   irq_o                IRQ_PEND & IRQ_MASK
//   irq_id_o             {valid, lowest pending index}
//   fetch_enable_i/_o    async fetch enable in, gated fetch enable out
//   clk_gate_core_o      1 = core clock runs
//   core_busy_i          core busy; sleep is entered only when idle
module apb_irq_event_ctrl #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NB_LINES       = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int WAKE_CYCLES    = 4
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NB_LINES-1:0]       irq_i,
    input  logic [NB_LINES-1:0]       event_i,
    output logic [NB_LINES-1:0]       irq_o,
    output logic [5:0]                irq_id_o,
    input  logic                      fetch_enable_i,
    output logic                      fetch_enable_o,
    output logic                      clk_gate_core_o,
    input  logic                      core_busy_i
);

    localparam int CW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_SLEEP     = 2'd2,
        ST_WAKE      = 2'd3
    } state_t;

    logic [NB_LINES-1:0]    r_irq_mask, r_irq_pend, r_evt_mask, r_evt_pend, r_edge_mode;
    logic [NB_LINES-1:0]    r_irq_q, r_evt_q;
    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_wcnt, w_wcnt_nxt;

    logic                   w_unmapped, w_wr, w_wake, w_sleep_req;
    logic [2:0]             w_sel;
    logic [NB_LINES-1:0]    w_wdat, w_irq_act, w_evt_act, w_irq_out;
    logic [NB_LINES-1:0]    w_irq_clr, w_irq_set, w_evt_clr;
    logic [4:0]             w_id;
    logic                   w_id_vld, w_clk_gate, w_fsm_fetch;
    logic [31:0]            w_rdata;
    logic                   w_unused;

    // Anything at 0x20 or above aliases nothing: no side effect, error response.
    assign w_unmapped  = (PADDR >> 5) != '0;
    assign w_sel       = PADDR[4:2];
    assign w_wr        = PSEL & PENABLE & PWRITE & ~w_unmapped;
    assign w_wdat      = PWDATA[NB_LINES-1:0];
    assign w_unused    = ^{PADDR[1:0], PWDATA};

    assign w_irq_clr   = (w_wr && w_sel == 3'd1) ? w_wdat : '0;
    assign w_irq_set   = (w_wr && w_sel == 3'd2) ? w_wdat : '0;
    assign w_evt_clr   = (w_wr && w_sel == 3'd4) ? w_wdat : '0;
    assign w_sleep_req = w_wr && (w_sel == 3'd7) && PWDATA[0];

    // Edge lines fire once per rising edge, level lines fire every cycle high.
    assign w_irq_act = (irq_i   & ~r_irq_q & r_edge_mode) | (irq_i   & ~r_edge_mode);
    assign w_evt_act = (event_i & ~r_evt_q & r_edge_mode) | (event_i & ~r_edge_mode);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_irq_mask  <= '0;
            r_irq_pend  <= '0;
            r_evt_mask  <= '0;
            r_evt_pend  <= '0;
            r_edge_mode <= '0;
            r_irq_q     <= '0;
            r_evt_q     <= '0;
            r_sync      <= '0;
        end else begin
            r_irq_q <= irq_i;
            r_evt_q <= event_i;
            r_sync  <= {r_sync[SYNC_STAGES-2:0], fetch_enable_i};
            if (w_wr && w_sel == 3'd0) r_irq_mask  <= w_wdat;
            if (w_wr && w_sel == 3'd3) r_evt_mask  <= w_wdat;
            if (w_wr && w_sel == 3'd5) r_edge_mode <= w_wdat;
            // Capture is OR'd in after the clear so a same-cycle capture wins.
            r_irq_pend <= (r_irq_pend & ~w_irq_clr) | w_irq_set | w_irq_act;
            r_evt_pend <= (r_evt_pend & ~w_evt_clr) | w_evt_act;
        end
    end

    assign w_irq_out = r_irq_pend & r_irq_mask;
    assign w_wake    = (|w_irq_out) | (|(r_evt_pend & r_evt_mask));

    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        w_id     = '0;
        w_id_vld = 1'b0;
        for (int i = NB_LINES - 1; i >= 0; i--) begin
            if (w_irq_out[i]) begin
                w_id     = 5'(i);
                w_id_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_RUN;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_clk_gate  = 1'b1;
        w_fsm_fetch = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_fsm_fetch = 1'b1;
                if (w_sleep_req) w_state_nxt = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (w_wake)            w_state_nxt = ST_RUN;
                else if (!core_busy_i) w_state_nxt = ST_SLEEP;
            end
            ST_SLEEP: begin
                w_clk_gate = 1'b0;
                w_wcnt_nxt = CW'(WAKE_CYCLES - 1);
                if (w_wake) w_state_nxt = ST_WAKE;
            end
            ST_WAKE: begin
                if (r_wcnt == '0) w_state_nxt = ST_RUN;
                else              w_wcnt_nxt  = r_wcnt - 1'b1;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        if (!w_unmapped) begin
            case (w_sel)
                3'd0:    w_rdata[NB_LINES-1:0] = r_irq_mask;
                3'd1:    w_rdata[NB_LINES-1:0] = r_irq_pend;
                3'd3:    w_rdata[NB_LINES-1:0] = r_evt_mask;
                3'd4:    w_rdata[NB_LINES-1:0] = r_evt_pend;
                3'd5:    w_rdata[NB_LINES-1:0] = r_edge_mode;
                3'd6:    w_rdata = {w_id_vld, 26'd0, w_id};
                3'd7:    w_rdata = {29'd0, r_state, (r_state == ST_SLEEP)};
                default: w_rdata = '0;
            endcase
        end
    end

    assign PRDATA          = w_rdata;
    assign PREADY          = 1'b1;
    assign PSLVERR         = PSEL & PENABLE & w_unmapped;
    assign irq_o           = w_irq_out;
    assign irq_id_o        = {w_id_vld, w_id};
    assign fetch_enable_o  = r_sync[SYNC_STAGES-1] & w_fsm_fetch;
    assign clk_gate_core_o = w_clk_gate;

endmodule

// File: doc/apb_irq_event_ctrl.md
Name: apb_irq_event_ctrl

Overview:
Parametrised APB interrupt/event controller with integrated sleep control. Generalises the fixed 32-line interrupt/event/sleep unit. Adds:
- configurable line count
- per-line edge/level capture
- set/clear registers and a prioritised IRQ ID register
- a sleep FSM with a programmable wake-up guard interval

It sits between peripheral interrupt/event sources and one core, and drives the core's irq lines, fetch enable and clock-gate enable.

Parameters:
APB_ADDR_WIDTH, 12, APB address width.
NB_LINES, 32, number of irq lines and number of event lines; legal range 1..32.
SYNC_STAGES, 2, fetch_enable_i synchroniser depth; minimum 2.
WAKE_CYCLES, 4, HCLK cycles the core clock runs before fetch is re-enabled after wake; minimum 1.

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
PADDR  in  APB_ADDR_WIDTH  APB address; only PADDR[4:2] decoded
PWDATA  in  32  APB write data
PWRITE  in  1  APB write
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PRDATA  out  32  APB read data
PREADY  out  1  always 1
PSLVERR  out  1  1 on access to an unmapped offset
irq_i  in  NB_LINES  interrupt sources, synchronous to HCLK
event_i  in  NB_LINES  event sources, synchronous to HCLK
irq_o  out  NB_LINES  masked pending interrupts to the core
irq_id_o  out  6  {valid, 5-bit lowest pending index}
fetch_enable_i  in  1  asynchronous fetch enable
fetch_enable_o  out  1  fetch enable to the core
clk_gate_core_o  out  1  core clock enable, 1 = clock runs
core_busy_i  in  1  core busy status

Reset and clock: reset HRESETn, asynchronous, active-low; clock HCLK.

Behaviour:
- APB access:
  - Zero wait states.
  - A write commits on PSEL&PENABLE&PWRITE.
  - Reads are combinational from the registers.
  - Bits at or above NB_LINES read 0 and ignore writes.
- Register map (byte offset):
  - 0x00 IRQ_MASK: RW.
  - 0x04 IRQ_PEND: R; write-1-to-clear.
  - 0x08 IRQ_SET: W1S into IRQ_PEND; reads 0.
  - 0x0C EVT_MASK: RW.
  - 0x10 EVT_PEND: R; W1C.
  - 0x14 EDGE_MODE: RW. Bit i=1 selects rising-edge capture for both irq_i[i] and event_i[i]; bit i=0 selects level capture.
  - 0x18 IRQ_ID: R; {bit31 valid, bits4:0 id}.
  - 0x1C SLEEP_CTRL: write bit0=1 requests sleep. Read gives bit0=asleep (SLEEP state) and bits2:1=FSM state code.
  - Offsets 0x20 and above are unmapped: PSLVERR=1, PRDATA=0, no register side effect.
- Capture: each cycle, pend[i] is set when the source is active.
  - Edge mode: line & ~line_q, where line_q is a 1-cycle delayed copy reset to 0.
  - Level mode: line high.
  - Pending bits are sticky until cleared.
  - A capture and a W1C on the same bit in the same cycle: the set wins.
- irq_o = IRQ_PEND & IRQ_MASK.
- irq_id_o and IRQ_ID give the lowest index set in irq_o. valid=0 and id=0 when none is set.
- wake = |irq_o | |(EVT_PEND & EVT_MASK).
- Sleep FSM states:
  - RUN (code 0): entered from reset. Goes to WAIT_IDLE on a sleep-request write.
  - WAIT_IDLE (1): returns to RUN if wake is set. Otherwise goes to SLEEP when core_busy_i=0.
  - SLEEP (2): goes to WAKE when wake is set.
  - WAKE (3): loads a counter with WAKE_CYCLES-1, decrements it each cycle, and goes to RUN when the counter reaches 0.
  - A sleep-request write in any state other than RUN is ignored.
  - A request written while wake is already set goes RUN -> WAIT_IDLE -> RUN, with 1 cycle in WAIT_IDLE.
- FSM outputs:
  - clk_gate_core_o = 0 only in SLEEP.
  - fsm_fetch = 1 only in RUN.
- Fetch-enable synchroniser: fetch_enable_i passes through SYNC_STAGES flops, all reset to 0. fetch_enable_o = sync_out & fsm_fetch.
- Reset values:
  - All registers 0, FSM in RUN.
  - irq_o=0, irq_id_o=0, fetch_enable_o=0.
  - clk_gate_core_o=1, PRDATA=0, PSLVERR=0, PREADY=1.
- Reset asserted mid-sleep returns the FSM to RUN immediately, with clock enabled and pending bits cleared.

Test Plan:
- Reset, hold fetch_enable_i=1 -> fetch_enable_o stays 0 for SYNC_STAGES cycles, then goes 1; clk_gate_core_o=1 throughout; all register reads return 0.
- IRQ_MASK=0x0000_0030, EDGE_MODE=0, pulse irq_i[5] for 1 cycle -> IRQ_PEND=0x20, irq_o=0x20, IRQ_ID=0x8000_0005. Then pulse irq_i[4] -> IRQ_ID=0x8000_0004. W1C 0x10 -> IRQ_ID=0x8000_0005.
- EDGE_MODE bit3=1, hold irq_i[3] high for 10 cycles -> exactly one capture. W1C on bit3 while irq_i[3] is still high -> bit stays 0. Same test with EDGE_MODE=0 -> bit re-sets the next cycle. Same-cycle capture plus W1C -> bit reads 1.
- EVT_MASK=0x1, core_busy_i=1, write SLEEP_CTRL=1 -> FSM stays in WAIT_IDLE. Drop busy -> SLEEP and clk_gate_core_o=0. Pulse event_i[0] -> clk_gate_core_o=1 next cycle, fetch_enable_o=1 exactly WAKE_CYCLES cycles after entering WAKE.
- Sleep request with an irq already pending and masked -> never reaches SLEEP; clk_gate_core_o stays 1. Access to offset 0x24 -> PSLVERR=1, PRDATA=0.
- NB_LINES=8: write 0xFFFF_FFFF to IRQ_MASK -> reads 0x0000_00FF. Assert HRESETn low while in SLEEP -> clk_gate_core_o=1 and the FSM code reads 0.
